dff_pipeline: RTL and testbench

- Parametrised chain of enabled D-register stages carrying WIDTH-bit data from input to output.
- Each stage has a valid bit and a valid/ready handshake, so bubbles collapse and backpressure propagates upstream.
- A synchronous flush clears all stages.
- Used as the standard retiming/delay element between datapath blocks; generalises the single D flip-flop to width, depth, enable, stall and flush.

---
 rtl/dff_pipeline_pkg.sv | 12 +
 rtl/dff_pipeline_stage.sv | 37 +++
 rtl/dff_pipeline.sv | 101 ++++++++++
 tb/tb_dff_pipeline.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_pipeline_pkg.sv
// Shared constants for the retiming pipeline and its neighbours in the datapath.
package dff_pipeline_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultDepth = 4;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipeline_stage.sv
// One enabled register stage: data plus valid bit, loads on advance, valid cleared by flush.
module dff_stage
  import dff_pipeline_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefaultWidth,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             v_in,
  output logic [WIDTH-1:0] d_out,
  output logic             v_out
);

  logic [WIDTH-1:0] r_d;
  logic             r_v;

  // Flush drops the valid bit only; data holds so out_data stays deterministic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_d <= RESET_VAL;
      r_v <= 1'b0;
    end else if (flush) begin
      r_v <= 1'b0;
    end else if (load) begin
      r_d <= d_in;
      r_v <= v_in;
    end
  end

  assign d_out = r_d;
  assign v_out = r_v;

endmodule

// File: rtl/dff_pipeline.sv
// Handshaked chain of DEPTH register stages with bubble collapse, flush and occupancy count.
module dff_pipeline
  import dff_pipeline_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefaultWidth,
  parameter int unsigned      DEPTH     = DefaultDepth,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OccW = occ_width(DEPTH);

  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_rdy;
  logic [WIDTH-1:0] w_d [DEPTH];
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [OccW-1:0]  r_occ;
  logic [OccW-1:0]  w_occ_next;

  // rdy[i] = !v[i] || rdy[i+1], unrolled so each bit depends only on valids and out_ready.
  always_comb begin
    w_rdy = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_rdy[i] = out_ready;
      for (int j = i; j < int'(DEPTH); j++) begin
        w_rdy[i] = w_rdy[i] | !w_v[j];
      end
    end
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    logic [WIDTH-1:0] w_src_d;
    logic             w_src_v;

    if (i == 0) begin : g_head
      assign w_src_d = in_data;
      assign w_src_v = in_valid;
    end else begin : g_body
      assign w_src_d = w_d[i-1];
      assign w_src_v = w_v[i-1];
    end

    dff_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .load  (w_rdy[i]),
      .d_in  (w_src_d),
      .v_in  (w_src_v),
      .d_out (w_d[i]),
      .v_out (w_v[i])
    );
  end

  assign in_ready   = w_rdy[0] && !flush && !reset;
  assign out_valid  = w_v[DEPTH-1];
  assign out_data   = w_d[DEPTH-1];
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_comb begin
    w_occ_next = r_occ;
    if (flush) begin
      w_occ_next = '0;
    end else begin
      unique case ({w_in_xfer, w_out_xfer})
        2'b10:   w_occ_next = r_occ + OccW'(1);
        2'b01:   w_occ_next = r_occ - OccW'(1);
        default: w_occ_next = r_occ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occ_next;
    end
  end

  assign occupancy = r_occ;

  occ_matches_valid : assert property (@(posedge clk) disable iff (reset)
    (r_occ == OccW'($countones(w_v))) && (r_occ <= OccW'(DEPTH)));

endmodule

// File: tb/tb_dff_pipeline.sv
// Directed and random checks of dff_pipeline at DEPTH=4 and DEPTH=1 against a queue model.
module tb_dff_pipeline;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush4 = 1'b0, iv4 = 1'b0, ordy4 = 1'b1;
  logic       flush1 = 1'b0, iv1 = 1'b0, ordy1 = 1'b1;
  logic [7:0] id4 = '0, id1 = '0;
  logic       ir4, ov4, ir1, ov1;
  logic [7:0] od4, od1;
  logic [2:0] occ4;
  logic [0:0] occ1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] q4[$];
  logic [7:0] q1[$];
  int         a4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dff_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h5A)) dut4 (
    .clk(clk), .reset(reset), .flush(flush4), .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .occupancy(occ4)
  );

  dff_pipeline #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut1 (
    .clk(clk), .reset(reset), .flush(flush1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .occupancy(occ1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: the pipeline is a FIFO of accepted words, each leaving no
  // earlier than DEPTH edges after it entered; an empty or full pipe has a fixed handshake.
  always @(negedge clk) begin
    if (reset) begin
      q4.delete();
      a4.delete();
    end else begin
      chk("m4_occ", 32'(occ4), 32'(q4.size()));
      if (q4.size() == 0) begin
        chk("m4_empty_ovalid", 32'(ov4), 32'(0));
        chk("m4_empty_iready", 32'(ir4), 32'(!flush4));
      end
      if (q4.size() == 4) begin
        chk("m4_full_ovalid", 32'(ov4), 32'(1));
        chk("m4_full_iready", 32'(ir4), 32'(ordy4 && !flush4));
      end
      if (ov4 && ordy4 && q4.size() != 0) begin
        chk("m4_out_data", 32'(od4), 32'(q4[0]));
        chk("m4_latency", 32'((cyc - a4[0]) >= 4), 32'(1));
        void'(q4.pop_front());
        void'(a4.pop_front());
      end
      if (flush4) begin
        q4.delete();
        a4.delete();
      end else if (iv4 && ir4) begin
        q4.push_back(id4);
        a4.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      q1.delete();
    end else begin
      chk("m1_occ", 32'(occ1), 32'(q1.size()));
      chk("m1_ovalid", 32'(ov1), 32'(q1.size() != 0));
      chk("m1_iready", 32'(ir1), 32'((q1.size() == 0 || ordy1) && !flush1));
      if (ov1 && ordy1 && q1.size() != 0) begin
        chk("m1_out_data", 32'(od1), 32'(q1[0]));
        void'(q1.pop_front());
      end
      if (flush1) q1.delete();
      else if (iv1 && ir1) q1.push_back(id1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int n;

    #1 reset = 1'b1;
    #2;
    chk("rst_ovalid4", 32'(ov4), 32'(0));
    chk("rst_odata4", 32'(od4), 32'h5A);
    chk("rst_occ4", 32'(occ4), 32'(0));
    chk("rst_iready4", 32'(ir4), 32'(0));
    chk("rst_iready1", 32'(ir1), 32'(0));
    chk("rst_odata1", 32'(od1), 32'h00);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rel_iready4", 32'(ir4), 32'(1));
    chk("rel_iready1", 32'(ir1), 32'(1));

    // Latency: three back-to-back words through an unstalled 4-stage pipe.
    ordy4 = 1'b1; iv4 = 1'b1; id4 = 8'h11;
    step(); id4 = 8'h22;
    step(); id4 = 8'h33;
    step(); iv4 = 1'b0;
    chk("lat_occ_peak", 32'(occ4), 32'(3));
    chk("lat_not_yet", 32'(ov4), 32'(0));
    step();
    chk("lat_first_valid", 32'(ov4), 32'(1));
    chk("lat_first_data", 32'(od4), 32'h11);
    chk("lat_first_occ", 32'(occ4), 32'(3));
    step();
    chk("lat_second_data", 32'(od4), 32'h22);
    chk("lat_second_occ", 32'(occ4), 32'(2));
    step();
    chk("lat_third_data", 32'(od4), 32'h33);
    step();
    chk("lat_drained_valid", 32'(ov4), 32'(0));
    chk("lat_drained_occ", 32'(occ4), 32'(0));

    // Full stall: only four of six words get in.
    ordy4 = 1'b0; iv4 = 1'b1; idx = 0;
    for (int k = 0; k < 6; k++) begin
      id4 = 8'(8'hA0 + idx);
      #1;
      if (ir4) idx++;
      step();
    end
    chk("stall_accepted", 32'(idx), 32'(4));
    chk("stall_iready", 32'(ir4), 32'(0));
    chk("stall_occ", 32'(occ4), 32'(4));
    chk("stall_head", 32'(od4), 32'hA0);
    ordy4 = 1'b1; n = 0;
    for (int k = 0; k < 40 && n < 6; k++) begin
      iv4 = (idx < 6);
      id4 = 8'(8'hA0 + idx);
      #1;
      if (ov4) begin
        chk("stall_order", 32'(od4), 32'(8'hA0 + n));
        n++;
      end
      if (iv4 && ir4) idx++;
      step();
    end
    iv4 = 1'b0;
    chk("stall_drained_count", 32'(n), 32'(6));
    step();
    chk("stall_empty_occ", 32'(occ4), 32'(0));

    // Bubble collapse: two words separated by idle cycles pack against a stalled output.
    ordy4 = 1'b0; iv4 = 1'b1; id4 = 8'h01;
    step(); iv4 = 1'b0;
    step();
    step(); iv4 = 1'b1; id4 = 8'h02;
    step(); iv4 = 1'b0;
    repeat (3) step();
    chk("bub_occ", 32'(occ4), 32'(2));
    chk("bub_head", 32'(od4), 32'h01);
    chk("bub_iready", 32'(ir4), 32'(1));
    ordy4 = 1'b1;
    #1;
    chk("bub_out1_valid", 32'(ov4), 32'(1));
    step();
    chk("bub_out2_valid", 32'(ov4), 32'(1));
    chk("bub_out2_data", 32'(od4), 32'h02);
    step();
    chk("bub_done", 32'(ov4), 32'(0));

    // Flush beats a simultaneous input; the flushed words and 0xFF never appear.
    ordy4 = 1'b0; iv4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      id4 = 8'(8'hB1 + k);
      step();
    end
    iv4 = 1'b0;
    repeat (2) step();
    chk("fl_occ_before", 32'(occ4), 32'(3));
    flush4 = 1'b1; iv4 = 1'b1; id4 = 8'hFF;
    #1;
    chk("fl_iready", 32'(ir4), 32'(0));
    step();
    flush4 = 1'b0; iv4 = 1'b0;
    chk("fl_occ_after", 32'(occ4), 32'(0));
    chk("fl_ovalid_after", 32'(ov4), 32'(0));
    ordy4 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("fl_no_output", 32'(ov4), 32'(0));
      step();
    end

    // Asynchronous reset between edges with a full pipe.
    ordy4 = 1'b0; iv4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      id4 = 8'(8'hC0 + k);
      step();
    end
    iv4 = 1'b0;
    chk("ar_occ_full", 32'(occ4), 32'(4));
    #2 reset = 1'b1;
    #1;
    chk("ar_ovalid", 32'(ov4), 32'(0));
    chk("ar_odata", 32'(od4), 32'h5A);
    chk("ar_occ", 32'(occ4), 32'(0));
    chk("ar_iready", 32'(ir4), 32'(0));
    step();
    reset = 1'b0;
    #1;
    chk("ar_release_iready", 32'(ir4), 32'(1));

    // DEPTH=1 handshake pinned by hand.
    ordy1 = 1'b0; iv1 = 1'b1; id1 = 8'h77;
    step(); iv1 = 1'b0;
    chk("d1_valid", 32'(ov1), 32'(1));
    chk("d1_data", 32'(od1), 32'h77);
    chk("d1_occ", 32'(occ1), 32'(1));
    chk("d1_full_iready", 32'(ir1), 32'(0));
    ordy1 = 1'b1;
    #1;
    chk("d1_pass_iready", 32'(ir1), 32'(1));
    step();

    // Random traffic on both instances, checked by the models.
    for (int k = 0; k < 1000; k++) begin
      iv1    = 1'($urandom_range(0, 1));
      ordy1  = 1'($urandom_range(0, 1));
      id1    = 8'($urandom);
      flush1 = ($urandom_range(0, 31) == 0);
      iv4    = 1'($urandom_range(0, 1));
      ordy4  = ($urandom_range(0, 3) != 0);
      id4    = 8'($urandom);
      flush4 = ($urandom_range(0, 47) == 0);
      step();
    end
    iv1 = 1'b0; ordy1 = 1'b1; flush1 = 1'b0;
    iv4 = 1'b0; ordy4 = 1'b1; flush4 = 1'b0;
    repeat (6) step();
    chk("end_occ4", 32'(occ4), 32'(0));
    chk("end_occ1", 32'(occ1), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
